// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive sides.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with first-word fall-through read data.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_wr;
    logic        do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance; push and pop in one cycle both take effect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered byte serializer, start + 8 data LSB-first + stop.
// Define UART_TX_PARITY_EN to insert an even parity bit before stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int            BW        = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0] BAUD_LAST = BW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      live;
`ifdef UART_TX_PARITY_EN
    logic                      parity;
`endif

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       baud_end;
    logic [7:0] head;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign ready    = live && !full;
    assign push     = valid && ready;
    assign busy     = (state != IDLE) || !empty;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Pop when leaving IDLE or when chaining a frame straight out of STOP
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            STOP:    pop = baud_end && !empty;
            default: pop = 1'b0;
        endcase
    end

    // Hold ready low through reset, release once reset is sampled high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Frame sequencer; tx is registered with the value of the next bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (!empty) begin
                        shift <= head;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_end) begin
                        if (!empty) begin
                            shift <= head;
`ifdef UART_TX_PARITY_EN
                            parity <= ^head;
`endif
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx.
// Frames are decoded mid-bit and compared with a queue of accepted bytes.
module tb_uart_tx;

    localparam int OS    = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FCYC = NB * OS;
    localparam int MAXF = 16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data    = '0;
    logic       valid   = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]    src     [MAXF];
    logic [7:0]    rx_byte [MAXF];
    logic [NB-1:0] rx_bits [MAXF];
    int            rx_fall [MAXF];
    logic          rx_rb   [MAXF];
    logic          rx_ra   [MAXF];
    bit            rx_to   [MAXF];

    uart_tx #(
        .OVERSAMPLE (OS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected line levels of one frame, index 0 = start bit
    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = (($countones(b) % 2) == 1);
`endif
        return f;
    endfunction

    task automatic recv_n(input int n);
        for (int j = 0; j < n; j++) begin
            int   w;
            logic prev;
            w          = 0;
            prev       = ready;
            rx_to[j]   = 1'b0;
            rx_bits[j] = '0;
            rx_byte[j] = '0;
            @(negedge clk);
            while (tx !== 1'b0 && w < 4000) begin
                prev = ready;
                w++;
                @(negedge clk);
            end
            if (tx !== 1'b0) begin
                for (int k = j; k < n; k++) rx_to[k] = 1'b1;
                return;
            end
            rx_fall[j] = cyc;
            rx_rb[j]   = prev;
            rx_ra[j]   = ready;
            repeat (7) @(negedge clk);
            rx_bits[j][0] = tx;
            for (int i = 1; i < NB; i++) begin
                repeat (16) @(negedge clk);
                rx_bits[j][i] = tx;
            end
            rx_byte[j] = rx_bits[j][8:1];
        end
    endtask

    task automatic send_one(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        while (ready !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (w >= 4000) begin
            errors++;
            $display("FAIL send_accept ready=%b required 1", ready);
        end
    endtask

    task automatic drive_stream(input int n);
        int idx;
        int w;
        idx = 0;
        w   = 0;
        while (idx < n && w < 6000) begin
            @(negedge clk);
            data  = src[idx];
            valid = 1'b1;
            if (ready === 1'b1) idx++;
            w++;
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL stream_accepts got %0d required %0d", idx, n);
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait busy=%b required 0", busy);
        end
    endtask

    task automatic check_frames(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            checks++;
            if (rx_to[j] || rx_bits[j] !== frame_of(src[j])) begin
                errors++;
                $display("FAIL %s frame %0d got %h bits %b required %h bits %b to=%0d",
                         tag, j, rx_byte[j], rx_bits[j], src[j],
                         frame_of(src[j]), rx_to[j]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_tx got %b required 1", tx);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b required 0", busy);
        end
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got %b required 0", ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_ready got %b required 1", ready);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rel_busy got %b required 0", busy);
        end
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rel_tx got %b required 1", tx);
        end
    endtask

    task automatic test_single();
        logic [NB-1:0] bits;
        logic          hi;
        wait_idle();
        send_one(8'hA5);
        checks += 2;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL lat_early tx=%b required 1", tx);
        end
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL lat_busy busy=%b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL lat_start tx=%b required 0", tx);
        end
        repeat (7) @(negedge clk);
        bits[0] = tx;
        for (int i = 1; i < NB; i++) begin
            repeat (16) @(negedge clk);
            bits[i] = tx;
        end
        checks++;
        if (bits !== frame_of(8'hA5)) begin
            errors++;
            $display("FAIL a5_bits got %b required %b", bits, frame_of(8'hA5));
        end
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold got %b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall got %b required 0", busy);
        end
        hi = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) hi = 1'b0;
        end
        checks++;
        if (hi !== 1'b1) begin
            errors++;
            $display("FAIL idle_line got %b required 1", hi);
        end
    endtask

    task automatic test_values();
        logic [7:0] v [4];
        v[0] = 8'h3C;
        v[1] = 8'h00;
        v[2] = 8'hFF;
        v[3] = 8'h80;
        for (int k = 0; k < 4; k++) begin
            wait_idle();
            src[0] = v[k];
            fork
                send_one(v[k]);
                recv_n(1);
            join
            check_frames("value", 1);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        for (int i = 0; i < 5; i++) src[i] = 8'(17 * (i + 1));
        fork
            begin
                drive_stream(5);
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full ready=%b required 0", ready);
                end
            end
            recv_n(5);
        join
        check_frames("b2b", 5);
        for (int j = 1; j < 5; j++) begin
            checks++;
            if (rx_fall[j] - rx_fall[j-1] != FCYC) begin
                errors++;
                $display("FAIL b2b_gap %0d got %0d required %0d",
                         j, rx_fall[j] - rx_fall[j-1], FCYC);
            end
        end
    endtask

    task automatic test_push_on_pop();
        wait_idle();
        for (int i = 0; i < 10; i++) src[i] = 8'($urandom);
        fork
            drive_stream(10);
            recv_n(10);
        join
        check_frames("pop_push", 10);
        for (int j = 1; j < 10; j++) begin
            checks++;
            if (rx_ra[j] !== 1'b1) begin
                errors++;
                $display("FAIL pop_ready %0d got %b required 1", j, rx_ra[j]);
            end
            if (j <= 10 - DEPTH) begin
                checks++;
                if (rx_rb[j] !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready %0d got %b required 0", j, rx_rb[j]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic hi;
        logic nb;
        wait_idle();
        send_one(8'hF0);
        data  = 8'h0F;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_start tx=%b required 0", tx);
        end
        repeat (71) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit3 tx=%b required 0", tx);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_tx got %b required 1", tx);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_busy got %b required 0", busy);
        end
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ready got %b required 0", ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rel_ready got %b required 1", ready);
        end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rel_busy got %b required 0", busy);
        end
        hi = 1'b1;
        nb = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) hi = 1'b0;
            if (busy !== 1'b0) nb = 1'b0;
        end
        checks += 2;
        if (hi !== 1'b1) begin
            errors++;
            $display("FAIL residual_tx got %b required 1", hi);
        end
        if (nb !== 1'b1) begin
            errors++;
            $display("FAIL residual_busy got %b required 1", nb);
        end
    endtask

    task automatic test_random();
        wait_idle();
        for (int i = 0; i < 12; i++) src[i] = 8'($urandom);
        fork
            begin
                for (int j = 0; j < 12; j++) begin
                    repeat ($urandom_range(0, 40)) @(negedge clk);
                    send_one(src[j]);
                end
            end
            recv_n(12);
        join
        check_frames("random", 12);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2];
        v[0] = 8'h07;
        v[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            wait_idle();
            src[0] = v[k];
            fork
                send_one(v[k]);
                recv_n(1);
            join
            check_frames("parity", 1);
            checks++;
            if (rx_bits[0][9] !== ((k == 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL parity_bit %h got %b", v[k], rx_bits[0][9]);
            end
            repeat (8) @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL parity_len_hold got %b required 1", busy);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL parity_len_end got %b required 0", busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_values();
        test_back_to_back();
        test_push_on_pop();
        test_reset_midframe();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter: the transmit side of the serial link whose receive side is `uart_rx`. It accepts bytes over a valid/ready handshake into a small FIFO. It serializes each byte onto `tx` as start bit, 8 data bits LSB-first, and stop bit. Each bit lasts 16 `clk` cycles, so `clk` is the same 16x-baud clock that drives `uart_rx`, and `uart_tx` output loops back cleanly into `uart_rx` input.

## Interface
- `OVERSAMPLE`, default 16: `clk` cycles per serial bit. Must be a power of two, at least 2.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, at least 2.
- `clk` input 1: single clock, rising-edge.
- `reset_n` input 1: synchronous, active-low reset. Sampled on the `clk` rising edge.
- `data` input 8: byte to send. Sampled when `valid && ready`.
- `valid` input 1: producer has a byte on `data`.
- `ready` output 1: FIFO can accept a byte.
- `tx` output 1: serial line, registered. Idle level is high.
- `busy` output 1: a frame is in progress or the FIFO is non-empty.

## Operation
- FSM states (`uart_pkg::tx_state_t`): IDLE, START, DATA, STOP, plus PARITY when enabled.
- IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the 8-bit shift register, clear `baud_cnt`, go to START, and register `tx`=0.
- START: `tx`=0 for OVERSAMPLE cycles. Then go to DATA with `bit_idx`=0.
- DATA: `tx`=shift[0] for OVERSAMPLE cycles per bit.
  - At each bit end: shift right and increment `bit_idx`.
  - After the bit with `bit_idx`=7: go to STOP (or PARITY when enabled).
- STOP: `tx`=1 for OVERSAMPLE cycles. At the end:
  - FIFO non-empty: pop and go directly to START. There is no idle gap between frames.
  - FIFO empty: go to IDLE.
- `baud_cnt` is log2(OVERSAMPLE) bits. It counts 0..OVERSAMPLE-1 and wraps. A bit ends when `baud_cnt`==OVERSAMPLE-1.
- `bit_idx` is 3 bits. Its wrap from 7 to 0 coincides with leaving DATA.
- FIFO:
  - Write on `valid && ready`. Read only on the FSM pop.
  - Pointers are log2(DEPTH)+1 bits, with the MSB used to distinguish full from empty.
  - `ready` = !full, derived from registered state only. There is no combinational path from the pop.
  - Simultaneous push and pop while neither full nor empty: both take effect, and occupancy is unchanged.
  - Push while full: impossible by protocol, since `ready`=0. If `valid` is high anyway, it is ignored.
- `busy` = (state != IDLE) || !empty.
- Reset (`reset_n`=0 at an edge), including mid-frame:
  - State becomes IDLE, FIFO is emptied, counters are cleared, and `tx`=1 from the next cycle.
  - A partial frame is abandoned and not resumed.
  - While `reset_n`=0: `ready`=0 and `busy`=0.

## Timing
- Reset values: `tx`=1, `busy`=0. `ready`=0 while reset is asserted, and `ready`=1 on the first cycle after `reset_n` rises.
- Byte accepted at edge E0, FSM in IDLE with FIFO empty:
  - FIFO becomes non-empty after E0.
  - Pop happens at E1, and `tx` falls after E1. Start latency is 2 edges.
- Frame length is 10×OVERSAMPLE cycles: 160 with defaults. With parity it is 11×OVERSAMPLE: 176.
- Back-to-back throughput is one byte per 160 cycles, with the stop bit followed immediately by the next start bit.
- A freed FIFO slot raises `ready` on the cycle after the pop edge.

## Configuration
- `UART_TX_PARITY_EN`, when defined:
  - Adds the PARITY state between DATA and STOP.
  - `tx` = XOR of the 8 data bits (even parity) for OVERSAMPLE cycles.
  - The XOR is computed at pop time into a parity register.
- Not defined: no parity state, no parity register, 10-bit frame. This is the default and is required for compatibility with `uart_rx`.

## Structure
- `uart_pkg` holds:
  - `tx_state_t`, a 3-bit enum.
  - `UART_DATA_BITS`=8.
  - The default OVERSAMPLE constant, shared with `uart_rx`.
- Sub-module `uart_tx_fifo`, parameterized by `DEPTH`, with ports `clk`, `reset_n`, `wr_en`, `wr_data[7:0]`, `rd_en`, `rd_data[7:0]`, `full`, `empty`.
  - `rd_data` shows the head entry combinationally (first-word fall-through).
- Top level holds the FSM, the counters, the shift register, and the `tx` output register.

## Test plan
- Reset, then send 0xA5 → `tx` per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1. `busy` falls 160 cycles after `tx` falls, and `tx` stays 1 afterward.
- Loopback `tx` into `uart_rx`, send 0x3C → `uart_rx` `data`=0x3C after the frame. Repeat for 0x00, 0xFF, 0x80.
- Hold `valid`=1 with 0x11, 0x22, 0x33, 0x44, 0x55 while `tx` is idle:
  - `ready` drops after 5 accepts, since one is popped immediately and 4 are stored.
  - Five frames go out contiguously: 800 cycles with no high gap longer than one stop bit.
- Push on the exact pop cycle while full → no byte is lost or duplicated, and the output byte order matches the input order.
- Assert `reset_n`=0 for 1 cycle during data bit 3 of 0xF0 → `tx`=1 the next cycle, FIFO is empty, `busy`=0, `ready`=1 after release. No residual frame is sent.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1 and a 176-cycle frame. Send 0x03 → parity bit 0.
